m_axi4l_snn_driver: RTL and testbench

AXI4-Lite master that drives one inference on the SNN coprocessor's AXI4-Lite slave register map. On START it writes every pixel to registers 0..IMAGE_SIZE-1 and pulses the image-fully-received flag at register FLAG_ADDR (write 1, then write 0). It then waits WAIT_CYCLES and reads the inferred digit from register RESULT_ADDR. It sits between the test/host sequencer and the coprocessor's slave interface.

---
 rtl/m_axi4l_snn_driver.sv | 186 ++++++++++++++++++
 tb/tb_m_axi4l_snn_driver.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_axi4l_snn_driver.sv
// AXI4-Lite master that loads one image into the SNN coprocessor, pulses its
// image-received flag, waits, then reads back the inferred digit.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for START
// S_WREQ  | AW and W presented; each channel retires on its own handshake
// S_WRESP | BREADY high, waiting for the write response
// S_WAIT  | down-counting the idle gap before the result read
// S_RREQ  | ARVALID high at the result register
// S_RRESP | RREADY high, waiting for the read data
module m_axi4l_snn_driver #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 9,
    parameter int IMAGE_SIZE     = 256,
    parameter int PIXEL_BITS     = 8,
    parameter int M              = 8,
    parameter int FLAG_ADDR      = 256,
    parameter int RESULT_ADDR    = 0,
    parameter int WAIT_CYCLES    = 1024
) (
    input  logic                                  ACLK,
    input  logic                                  ARESET,
    input  logic                                  START,
    input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] IMAGE,
    output logic                                  BUSY,
    output logic                                  DONE,
    output logic [M-1:0]                          DIGIT,
    output logic                                  ERROR,
    output logic [AXI_ADDR_WIDTH-1:0]             AWADDR,
    output logic [2:0]                            AWPROT,
    output logic                                  AWVALID,
    input  logic                                  AWREADY,
    output logic [AXI_DATA_WIDTH-1:0]             WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]           WSTRB,
    output logic                                  WVALID,
    input  logic                                  WREADY,
    input  logic [1:0]                            BRESP,
    input  logic                                  BVALID,
    output logic                                  BREADY,
    output logic [AXI_ADDR_WIDTH-1:0]             ARADDR,
    output logic [2:0]                            ARPROT,
    output logic                                  ARVALID,
    input  logic                                  ARREADY,
    input  logic [AXI_DATA_WIDTH-1:0]             RDATA,
    input  logic [1:0]                            RRESP,
    input  logic                                  RVALID,
    output logic                                  RREADY
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int PIX_W  = $clog2(IMAGE_SIZE);
    localparam int IDX_W  = PIX_W + 1;
    localparam int WCNT_W = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_WREQ, S_WRESP, S_WAIT, S_RREQ, S_RRESP} state_t;
    typedef enum logic [1:0] {PH_PIX, PH_SET, PH_CLR} phase_t;

    state_t              state;
    phase_t              phase;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_nxt;
    logic [PIX_W-1:0]    pix_sel;
    logic [WCNT_W-1:0]   wait_cnt;
    logic [AXI_DATA_WIDTH-1:0] pix_nxt_data;
    logic                unused_bits;

    assign idx_nxt      = idx + 1'b1;
    assign pix_sel      = idx_nxt[PIX_W-1:0];
    assign pix_nxt_data = AXI_DATA_WIDTH'(IMAGE[pix_sel]);
    assign AWPROT       = 3'b000;
    assign ARPROT       = 3'b000;
    assign unused_bits  = ^{RDATA[AXI_DATA_WIDTH-1:M], idx_nxt[IDX_W-1]};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state    <= S_IDLE;
            phase    <= PH_PIX;
            idx      <= '0;
            wait_cnt <= '0;
            AWADDR   <= '0;
            AWVALID  <= 1'b0;
            WDATA    <= '0;
            WSTRB    <= '0;
            WVALID   <= 1'b0;
            BREADY   <= 1'b0;
            ARADDR   <= '0;
            ARVALID  <= 1'b0;
            RREADY   <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            DIGIT    <= '0;
            ERROR    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        idx     <= '0;
                        ERROR   <= 1'b0;
                        phase   <= PH_PIX;
                        BUSY    <= 1'b1;
                        AWADDR  <= '0;
                        WDATA   <= AXI_DATA_WIDTH'(IMAGE[0]);
                        WSTRB   <= STRB_W'(1);
                        AWVALID <= 1'b1;
                        WVALID  <= 1'b1;
                        state   <= S_WREQ;
                    end
                end
                S_WREQ: begin
                    if (AWREADY) AWVALID <= 1'b0;
                    if (WREADY)  WVALID  <= 1'b0;
                    // a channel already retired counts as done for the pair
                    if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) begin
                        BREADY <= 1'b1;
                        state  <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (BVALID) begin
                        BREADY <= 1'b0;
                        if (BRESP != 2'b00) ERROR <= 1'b1;
                        case (phase)
                            PH_PIX: begin
                                idx <= idx_nxt;
                                if (idx == IDX_W'(IMAGE_SIZE - 1)) begin
                                    phase  <= PH_SET;
                                    AWADDR <= AXI_ADDR_WIDTH'(FLAG_ADDR);
                                    WDATA  <= AXI_DATA_WIDTH'(1);
                                    WSTRB  <= '1;
                                end else begin
                                    AWADDR <= AXI_ADDR_WIDTH'(idx_nxt);
                                    WDATA  <= pix_nxt_data;
                                end
                                AWVALID <= 1'b1;
                                WVALID  <= 1'b1;
                                state   <= S_WREQ;
                            end
                            PH_SET: begin
                                phase   <= PH_CLR;
                                WDATA   <= '0;
                                AWVALID <= 1'b1;
                                WVALID  <= 1'b1;
                                state   <= S_WREQ;
                            end
                            default: begin
                                wait_cnt <= WCNT_W'(WAIT_CYCLES);
                                state    <= S_WAIT;
                            end
                        endcase
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == WCNT_W'(1)) begin
                        wait_cnt <= '0;
                        ARADDR   <= AXI_ADDR_WIDTH'(RESULT_ADDR);
                        ARVALID  <= 1'b1;
                        state    <= S_RREQ;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_RREQ: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= S_RRESP;
                    end
                end
                S_RRESP: begin
                    if (RVALID) begin
                        RREADY <= 1'b0;
                        DIGIT  <= RDATA[M-1:0];
                        if (RRESP != 2'b00) ERROR <= 1'b1;
                        DONE   <= 1'b1;
                        BUSY   <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_axi4l_snn_driver.sv
// Scoreboard bench for m_axi4l_snn_driver: a delay-configurable AXI4-Lite
// slave model, an expected-transaction queue per run, and a decoupled monitor.
module tb_m_axi4l_snn_driver;
    localparam int DW = 32, AW = 9, NPIX = 256, PB = 8, MW = 8;
    localparam int FLAG = 256, RES = 0, WAITC = 1024;

    logic ACLK = 1'b0;
    logic ARESET, START;
    logic [NPIX-1:0][PB-1:0] IMAGE;
    logic BUSY, DONE, ERROR;
    logic [MW-1:0] DIGIT;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [2:0] AWPROT, ARPROT;
    logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic ARVALID, ARREADY, RVALID, RREADY;
    logic [DW-1:0] WDATA, RDATA;
    logic [3:0] WSTRB;
    logic [1:0] BRESP, RRESP;

    always #5 ACLK = ~ACLK;

    m_axi4l_snn_driver dut (
        .ACLK(ACLK), .ARESET(ARESET), .START(START), .IMAGE(IMAGE),
        .BUSY(BUSY), .DONE(DONE), .DIGIT(DIGIT), .ERROR(ERROR),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data; logic [3:0] strb;} wr_t;
    typedef struct packed {logic [MW-1:0] digit; logic err;} done_t;

    wr_t           exp_wr[$];
    logic [AW-1:0] exp_rd[$];
    done_t         exp_done[$];
    logic [AW-1:0] obs_aw[$];
    logic [DW+3:0] obs_w[$];

    int checks = 0, failures = 0;
    int cyc = 0, wr_seen = 0, rd_seen = 0, done_seen = 0;
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int err_pix = -1;
    bit r_err = 0;
    logic [DW-1:0] rdata_val = '0;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %0h expected nothing (cycle %0d)", name, act, cyc);
    endtask

    // Slave model: each READY/VALID follows after a configurable number of cycles.
    initial begin : slave
        int aw_c, w_c, b_c, ar_c, r_c;
        bit aw_got, w_got, b_pend, r_pend;
        bit s_aw, s_w, s_b, s_ar, s_r, v_aw, v_w, v_ar, rst;
        logic [AW-1:0] b_addr, cur_aw;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; b_addr = '0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RRESP = 0; RDATA = $urandom;
        forever begin
            @(negedge ACLK);
            s_aw = AWVALID && AWREADY; s_w = WVALID && WREADY; s_b = BVALID && BREADY;
            s_ar = ARVALID && ARREADY; s_r = RVALID && RREADY;
            v_aw = AWVALID; v_w = WVALID; v_ar = ARVALID; cur_aw = AWADDR; rst = ARESET;
            @(posedge ACLK);
            #1;
            if (rst) begin
                aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
                AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
            end else begin
                if (s_aw) begin aw_got = 1; b_addr = cur_aw; end
                if (s_w) w_got = 1;
                if (s_b) begin BVALID = 0; b_pend = 0; end
                if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_c = 0; end
                if (aw_dly == 0) AWREADY = 1;
                else if (s_aw) begin AWREADY = 0; aw_c = 0; end
                else if (v_aw && !AWREADY) begin aw_c++; if (aw_c >= aw_dly) AWREADY = 1; end
                if (w_dly == 0) WREADY = 1;
                else if (s_w) begin WREADY = 0; w_c = 0; end
                else if (v_w && !WREADY) begin w_c++; if (w_c >= w_dly) WREADY = 1; end
                if (b_pend && !BVALID) begin
                    if (b_c >= b_dly) begin
                        BVALID = 1;
                        BRESP = (err_pix >= 0 && b_addr == err_pix[AW-1:0]) ? 2'b10 : 2'b00;
                    end else b_c++;
                end
                if (ar_dly == 0) ARREADY = 1;
                else if (s_ar) begin ARREADY = 0; ar_c = 0; end
                else if (v_ar && !ARREADY) begin ar_c++; if (ar_c >= ar_dly) ARREADY = 1; end
                if (s_r) begin RVALID = 0; r_pend = 0; RDATA = $urandom; end
                if (s_ar) begin r_pend = 1; r_c = 0; end
                if (r_pend && !RVALID) begin
                    if (r_c >= r_dly) begin
                        RVALID = 1; RDATA = rdata_val; RRESP = r_err ? 2'b10 : 2'b00;
                    end else r_c++;
                end
            end
        end
    end

    // Monitor: pairs AW/W beats, compares against the expected queues.
    initial begin : monitor
        wr_t e;
        done_t d;
        logic [DW+3:0] wv;
        logic [AW-1:0] av;
        logic p_aw_st, p_w_st, p_ar_st, p_done, p_arv;
        logic [AW-1:0] p_awaddr, p_araddr;
        logic [DW+3:0] p_w;
        int last_b_cyc;
        p_aw_st = 0; p_w_st = 0; p_ar_st = 0; p_done = 0; p_arv = 0;
        p_awaddr = '0; p_araddr = '0; p_w = '0; last_b_cyc = 0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                obs_aw.delete(); obs_w.delete();
                p_aw_st = 0; p_w_st = 0; p_ar_st = 0; p_done = 0; p_arv = 0;
            end else begin
                if (p_aw_st) check("aw_stable", {AWVALID, AWADDR}, {1'b1, p_awaddr});
                if (p_w_st)  check("w_stable", {WVALID, WDATA, WSTRB}, {1'b1, p_w});
                if (p_ar_st) check("ar_stable", {ARVALID, ARADDR}, {1'b1, p_araddr});
                if (AWVALID && AWREADY) obs_aw.push_back(AWADDR);
                if (WVALID && WREADY) obs_w.push_back({WDATA, WSTRB});
                while (obs_aw.size() > 0 && obs_w.size() > 0) begin
                    av = obs_aw.pop_front();
                    wv = obs_w.pop_front();
                    wr_seen++;
                    if (exp_wr.size() == 0) flag_fail("unexpected_write", av);
                    else begin
                        e = exp_wr.pop_front();
                        check("wr_addr", av, e.addr);
                        check("wr_data", wv[DW+3:4], e.data);
                        check("wr_strb", wv[3:0], e.strb);
                    end
                end
                if (BVALID && BREADY) last_b_cyc = cyc;
                if (ARVALID && !p_arv) check("wait_len", cyc - last_b_cyc, WAITC + 1);
                if (ARVALID && ARREADY) begin
                    rd_seen++;
                    if (exp_rd.size() == 0) flag_fail("unexpected_read", ARADDR);
                    else check("rd_addr", ARADDR, exp_rd.pop_front());
                end
                if (p_done) check("done_pulse", DONE, 0);
                if (DONE) begin
                    done_seen++;
                    check("busy_at_done", BUSY, 0);
                    if (exp_done.size() == 0) flag_fail("unexpected_done", DIGIT);
                    else begin
                        d = exp_done.pop_front();
                        check("digit", DIGIT, d.digit);
                        check("error_at_done", ERROR, d.err);
                    end
                end
                p_aw_st = AWVALID && !AWREADY; p_awaddr = AWADDR;
                p_w_st = WVALID && !WREADY;    p_w = {WDATA, WSTRB};
                p_ar_st = ARVALID && !ARREADY; p_araddr = ARADDR;
                p_done = DONE; p_arv = ARVALID;
            end
        end
    end

    task automatic load_run(input bit ramp, input logic [DW-1:0] rd, input int epix, input bit rerr);
        for (int i = 0; i < NPIX; i++) IMAGE[i] = ramp ? i[PB-1:0] : PB'($urandom);
        rdata_val = rd; err_pix = epix; r_err = rerr;
        for (int i = 0; i < NPIX; i++)
            exp_wr.push_back('{addr: AW'(i), data: DW'(IMAGE[i]), strb: 4'b0001});
        exp_wr.push_back('{addr: AW'(FLAG), data: DW'(1), strb: 4'b1111});
        exp_wr.push_back('{addr: AW'(FLAG), data: DW'(0), strb: 4'b1111});
        exp_rd.push_back(AW'(RES));
        exp_done.push_back('{digit: rd[MW-1:0], err: (epix >= 0) || rerr});
    endtask

    task automatic pulse_start();
        @(posedge ACLK); #1 START = 1;
        @(posedge ACLK); #1 START = 0;
        @(negedge ACLK);
        check("busy_after_start", BUSY, 1);
        check("awvalid_after_start", AWVALID, 1);
        check("first_awaddr", AWADDR, 0);
        check("error_cleared", ERROR, 0);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_seen < target && n < 12000) begin @(posedge ACLK); n++; end
        @(negedge ACLK);
        check("run_completes", done_seen >= target, 1);
    endtask

    task automatic check_run(input int wr0, input int rd0);
        check("writes_per_run", wr_seen - wr0, NPIX + 2);
        check("reads_per_run", rd_seen - rd0, 1);
        check("wr_queue_drained", exp_wr.size(), 0);
    endtask

    task automatic check_reset_vals();
        @(negedge ACLK);
        check("rst_valids", {AWVALID, WVALID, ARVALID}, 0);
        check("rst_readies", {BREADY, RREADY}, 0);
        check("rst_busy_done_err", {BUSY, DONE, ERROR}, 0);
        check("rst_digit", DIGIT, 0);
        check("rst_addr", {AWADDR, ARADDR}, 0);
        check("rst_wdata_strb", {WDATA, WSTRB}, 0);
        check("rst_prot", {AWPROT, ARPROT}, 0);
    endtask

    task automatic set_delays(input int a, input int w, input int b, input int ar, input int r);
        aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    initial begin : driver
        int wr0, rd0, n;
        ARESET = 1; START = 0; IMAGE = '0;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 0;
        check_reset_vals();

        // nominal, zero-wait, ramp image, digit 7
        wr0 = wr_seen; rd0 = rd_seen;
        load_run(1, 32'hA5A5_A507, -1, 0);
        pulse_start();
        wait_done(1);
        check_run(wr0, rd0);

        // reset held 3 cycles while idle
        @(posedge ACLK); #1 ARESET = 1;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 0;
        check_reset_vals();

        // backpressure on every channel
        set_delays(4, 1, 3, 2, 5);
        wr0 = wr_seen; rd0 = rd_seen;
        load_run(0, $urandom, -1, 0);
        pulse_start();
        wait_done(2);
        check_run(wr0, rd0);

        // error responses on pixel 10 and on the read
        set_delays(0, 0, 0, 0, 0);
        wr0 = wr_seen; rd0 = rd_seen;
        load_run(0, $urandom, 10, 1);
        pulse_start();
        wait_done(3);
        check_run(wr0, rd0);

        // random delays, no errors; START must clear the sticky error
        set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3));
        wr0 = wr_seen; rd0 = rd_seen;
        load_run(0, $urandom, -1, 0);
        pulse_start();
        wait_done(4);
        check_run(wr0, rd0);

        // reset mid-run at pixel 100, then restart
        set_delays(0, 1, 1, 0, 0);
        wr0 = wr_seen;
        load_run(0, $urandom, -1, 0);
        pulse_start();
        n = 0;
        while (wr_seen - wr0 < 100 && n < 2000) begin @(posedge ACLK); n++; end
        check("reached_pixel_100", wr_seen - wr0 >= 100, 1);
        @(posedge ACLK); #1 ARESET = 1;
        exp_wr.delete(); exp_rd.delete(); exp_done.delete();
        @(posedge ACLK); #1 ARESET = 0;
        @(negedge ACLK);
        check("midrst_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY}, 0);
        check("midrst_busy", BUSY, 0);
        wr0 = wr_seen; rd0 = rd_seen;
        load_run(0, $urandom, -1, 0);
        pulse_start();
        wait_done(5);
        check_run(wr0, rd0);

        // START pulsed during WAIT is ignored
        set_delays(0, 0, 0, 0, 0);
        wr0 = wr_seen; rd0 = rd_seen;
        load_run(0, $urandom, -1, 0);
        pulse_start();
        n = 0;
        while (wr_seen - wr0 < NPIX + 2 && n < 3000) begin @(posedge ACLK); n++; end
        repeat (10) @(posedge ACLK);
        #1 START = 1;
        @(posedge ACLK); #1 START = 0;
        @(negedge ACLK);
        check("busy_in_wait", BUSY, 1);
        check("no_ar_in_wait", ARVALID, 0);
        wait_done(6);
        repeat (300) @(posedge ACLK);
        @(negedge ACLK);
        check("single_done", done_seen, 6);
        check("idle_after_ignored_start", {BUSY, AWVALID, ARVALID}, 0);
        check_run(wr0, rd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
